// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
//
// Purpose:
//   Collects NUM_SRC interrupt request lines. Each line can be in level mode or
//   rising-edge mode. The controller picks one eligible source, raises meip_o
//   toward the core, and tracks the claim until software completes it through
//   the CLAIM register.
//
// Optional feature:
//   Define IRQC_ROUND_ROBIN_EN to select round-robin arbitration. Without the
//   macro, the lowest eligible index wins (fixed priority).
//
// Ports:
//   clk_i        - single clock; all state updates on the rising edge
//   reset_i      - synchronous active-high reset
//   irq_src_i    - [NUM_SRC] interrupt request lines, synchronous to clk_i
//   irq_ack_i    - acknowledge pulse from the core
//   meip_o       - machine external interrupt request to the core
//   cfg_we_i     - register write strobe
//   cfg_addr_i   - register select: 0 ENABLE, 1 EDGE_SEL, 2 PENDING, 3 CLAIM
//   cfg_wdata_i  - register write data
//   cfg_rdata_o  - combinational read data for cfg_addr_i
//   dbg_state_o  - current FSM state (0 IDLE, 1 ASSERT, 2 SERVICE)
// -----------------------------------------------------------------------------
module irq_controller #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               irq_ack_i,
  output logic               meip_o,
  input  logic               cfg_we_i,
  input  logic [1:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic [31:0]        cfg_rdata_o,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_ENABLE   = 2'd0;
  localparam logic [1:0] ADDR_EDGE_SEL = 2'd1;
  localparam logic [1:0] ADDR_PENDING  = 2'd2;
  localparam logic [1:0] ADDR_CLAIM    = 2'd3;

  // Registered state
  state_e             state_q,    state_d;
  logic               meip_q,     meip_d;
  logic [ID_W-1:0]    claim_id_q, claim_id_d;
  logic [NUM_SRC-1:0] enable_q,   enable_d;
  logic [NUM_SRC-1:0] edge_sel_q, edge_sel_d;
  logic [NUM_SRC-1:0] pending_q,  pending_d;
  logic [NUM_SRC-1:0] src_prev_q, src_prev_d;

  // Combinational helpers
  logic               wr_enable, wr_edge_sel, wr_pending, wr_claim;
  logic [NUM_SRC-1:0] wdata_src;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] edge_next;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    win_idx;
  logic               claim_latch;
  logic               unused_wdata;

  // Upper write-data bits only matter for CLAIM/ENABLE widths below 32.
  assign unused_wdata = ^cfg_wdata_i;

  assign wr_enable   = cfg_we_i && (cfg_addr_i == ADDR_ENABLE);
  assign wr_edge_sel = cfg_we_i && (cfg_addr_i == ADDR_EDGE_SEL);
  assign wr_pending  = cfg_we_i && (cfg_addr_i == ADDR_PENDING);
  assign wr_claim    = cfg_we_i && (cfg_addr_i == ADDR_CLAIM);
  assign wdata_src   = cfg_wdata_i[NUM_SRC-1:0];

  assign rise        = irq_src_i & ~src_prev_q;
  assign eligible    = enable_q & pending_q;
  assign claim_latch = (state_q == ST_IDLE) && (|eligible);

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
`ifdef IRQC_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  // Search upward starting just after the last granted source, wrapping.
  always_comb begin
    logic found;
    win_id  = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      win_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_SRC);
      if (!found && eligible[win_idx]) begin
        win_id = win_idx;
        found  = 1'b1;
      end
    end
  end

  assign rr_ptr_d = claim_latch ? win_id : rr_ptr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_q <= ID_W'(NUM_SRC - 1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Scan from the top so the lowest eligible index is the last one written.
  always_comb begin
    win_id  = '0;
    win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      win_idx = ID_W'(i);
      if (eligible[win_idx]) begin
        win_id = win_idx;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM next state.
  // Handshake: meip_o acts as "valid" and irq_ack_i as "ready"; the claim is
  // handed to the core only in a cycle where the FSM is in ASSERT (meip_o = 1)
  // and irq_ack_i = 1. irq_ack_i outside ASSERT has no effect.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    claim_id_d = claim_id_q;
    ack_clr    = '0;
    case (state_q)
      ST_IDLE: begin
        if (claim_latch) begin
          state_d    = ST_ASSERT;
          claim_id_d = win_id;
        end
      end
      ST_ASSERT: begin
        if (irq_ack_i) begin
          state_d = ST_SERVICE;
          // Edge sources are consumed by the ack; level sources follow the pin.
          if (edge_sel_q[claim_id_q]) begin
            ack_clr[claim_id_q] = 1'b1;
          end
        end else if (!eligible[claim_id_q]) begin
          state_d    = ST_IDLE;
          claim_id_d = '0;
        end
      end
      ST_SERVICE: begin
        if (wr_claim && (cfg_wdata_i[ID_W-1:0] == claim_id_q)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        claim_id_d = '0;
      end
    endcase
    meip_d = (state_d == ST_ASSERT);
  end

  // ---------------------------------------------------------------------------
  // Register file next state
  // ---------------------------------------------------------------------------
  always_comb begin
    enable_d   = wr_enable   ? wdata_src : enable_q;
    edge_sel_d = wr_edge_sel ? wdata_src : edge_sel_q;
    src_prev_d = irq_src_i;
    // Clears are applied first so a coincident new edge keeps the bit set.
    edge_next  = (pending_q & ~(wr_pending ? wdata_src : '0) & ~ack_clr) | rise;
    pending_d  = (edge_sel_q & edge_next) | (~edge_sel_q & irq_src_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      meip_q     <= 1'b0;
      claim_id_q <= '0;
      enable_q   <= '0;
      edge_sel_q <= '0;
      pending_q  <= '0;
      src_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      meip_q     <= meip_d;
      claim_id_q <= claim_id_d;
      enable_q   <= enable_d;
      edge_sel_q <= edge_sel_d;
      pending_q  <= pending_d;
      src_prev_q <= src_prev_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    cfg_rdata_o = '0;
    case (cfg_addr_i)
      ADDR_ENABLE:   cfg_rdata_o[NUM_SRC-1:0] = enable_q;
      ADDR_EDGE_SEL: cfg_rdata_o[NUM_SRC-1:0] = edge_sel_q;
      ADDR_PENDING:  cfg_rdata_o[NUM_SRC-1:0] = pending_q;
      default: begin
        cfg_rdata_o[31]       = (state_q == ST_ASSERT) || (state_q == ST_SERVICE);
        cfg_rdata_o[ID_W-1:0] = claim_id_q;
      end
    endcase
  end

  assign meip_o      = meip_q;
  assign dbg_state_o = state_q;

endmodule
